// File: rtl/display_mode_ctrl.sv
// VGA source select sequencer: title screen, wait for camera, then user-selected
// processing mode. Buttons are debounced; select changes land only on frame_start.

module display_mode_ctrl_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  // cnt measures how long the synchronized sample has disagreed with level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module display_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_MODES       = 8,
  parameter int TITLE_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_home,
  input  logic       frame_start,
  input  logic       cam_ready,
  output logic [3:0] select_signal,
  output logic       mode_pending,
  output logic [1:0] state
);
  localparam logic [1:0] S_TITLE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam int         TW      = $clog2(TITLE_FRAMES + 1);

  logic [2:0] btn_raw, press;

  assign btn_raw = {btn_home, btn_prev, btn_next};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    display_mode_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .press (press[i])
    );
  end

  logic [3:0]    req_mode, req_n, sel_n, req_inc, req_dec;
  logic [1:0]    state_n;
  logic [TW-1:0] title_cnt, cnt_n;
  logic          home_req, home_n, pend_n;
  logic          do_next, do_prev, do_home;

  // home wins; next and prev together cancel each other
  assign do_home = press[2];
  assign do_next = press[0] & ~press[1] & ~press[2];
  assign do_prev = press[1] & ~press[0] & ~press[2];
  assign req_inc = (req_mode == 4'(NUM_MODES)) ? 4'd1 : req_mode + 4'd1;
  assign req_dec = (req_mode == 4'd1) ? 4'(NUM_MODES) : req_mode - 4'd1;

  always_comb begin
    state_n = state;
    sel_n   = select_signal;
    req_n   = req_mode;
    home_n  = home_req;
    cnt_n   = title_cnt;
    case (state)
      S_TITLE: begin
        sel_n  = 4'd0;
        home_n = 1'b0;
        if (frame_start) cnt_n = title_cnt + TW'(1);
        if (do_next || (frame_start && title_cnt == TW'(TITLE_FRAMES - 1))) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      end
      S_WAIT: begin
        sel_n  = 4'd0;
        home_n = 1'b0;
        if (do_home) begin
          state_n = S_TITLE;
          cnt_n   = '0;
        end else begin
          if (do_next)      req_n = req_inc;
          else if (do_prev) req_n = req_dec;
          if (frame_start && cam_ready) begin
            sel_n   = req_mode;
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (do_next)      req_n = req_inc;
        else if (do_prev) req_n = req_dec;
        if (do_home) home_n = 1'b1;
        // frame boundary: pending home beats camera loss beats mode apply
        if (frame_start) begin
          if (home_req) begin
            sel_n   = 4'd0;
            state_n = S_TITLE;
            cnt_n   = '0;
            home_n  = 1'b0;
          end else if (!cam_ready) begin
            sel_n   = 4'd0;
            state_n = S_WAIT;
          end else begin
            sel_n = req_mode;
          end
        end
      end
      default: begin
        state_n = S_TITLE;
        sel_n   = 4'd0;
        home_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
    pend_n = (state_n == S_RUN) && ((req_n != sel_n) || home_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_TITLE;
      select_signal <= 4'd0;
      req_mode      <= 4'd1;
      home_req      <= 1'b0;
      title_cnt     <= '0;
      mode_pending  <= 1'b0;
    end else begin
      state         <= state_n;
      select_signal <= sel_n;
      req_mode      <= req_n;
      home_req      <= home_n;
      title_cnt     <= cnt_n;
      mode_pending  <= pend_n;
    end
  end
endmodule
